// File: rtl/simd_seg_addsub.sv
// rtl/simd_seg_addsub.sv - pipelined SIMD lane-segmented adder/subtractor
//
// Purpose:
//   Splits an LEN-bit vector into 32-bit limbs and adds or subtracts A and B
//   on independent lanes of 32/64/128/... bits. The carry chain is cut at lane
//   boundaries. LIMBS_PER_STAGE limbs are resolved per pipeline stage, so the
//   latency is NS = (LEN/32)/LIMBS_PER_STAGE cycles.
//
// Optional feature macro: SIMD_SEG_CARRY_OUT_EN
//   When defined, adds carry_o[NL-1:0] with the carry-out of each lane-top limb.
//   For subtraction this is the no-borrow flag.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle
//   a_i, b_i   operands, LEN bits
//   width_i    thermometer lane code (bit0=64, bit1=128, ...; 0 = 32-bit lanes)
//   sub_i      0: A+B, 1: A-B
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   res_o      per-lane result, modulo 2^lane_width
//   carry_o    lane-top carry flags (only with SIMD_SEG_CARRY_OUT_EN)
module simd_seg_addsub #(
  parameter int LEN = 256,
  parameter int LIMBS_PER_STAGE = 2,
  localparam int NL = LEN / 32,
  localparam int NS = NL / LIMBS_PER_STAGE,
  localparam int WW = $clog2(NL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LEN-1:0]  a_i,
  input  logic [LEN-1:0]  b_i,
  input  logic [WW-1:0]   width_i,
  input  logic            sub_i,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef SIMD_SEG_CARRY_OUT_EN
  output logic [NL-1:0]   carry_o,
`endif
  output logic [LEN-1:0]  res_o
);

  // Limb idx starts a lane when its low k index bits are zero, where k is the
  // run of ones in w from bit0. Calling with idx+1 tells whether idx is the
  // top limb of its lane (idx+1 == NL has all low bits zero, so it qualifies).
  function automatic logic lane_start(input logic [WW-1:0] w, input int idx);
    logic run;
    logic st;
    run = 1'b1;
    st  = 1'b1;
    for (int j = 0; j < WW; j++) begin
      run = run & w[j];
      if (run && (((idx >> j) & 1) == 1)) st = 1'b0;
    end
    return st;
  endfunction

  // Stage register s holds the beat after stage s has resolved its limbs.
  logic [NS-1:0]               v_q, sub_q, c_q;
  logic [NS-1:0][WW-1:0]       w_q;
  logic [NS-1:0][LEN-1:0]      a_q, b_q, r_q;
  logic [NS-1:0][NL-1:0]       co_q;

  // Inputs seen by each stage: the ports for stage 0, the previous register otherwise.
  logic [NS-1:0]               v_src, sub_src, cin_src;
  logic [NS-1:0][WW-1:0]       w_src;
  logic [NS-1:0][LEN-1:0]      a_src, b_src, r_src;
  logic [NS-1:0][NL-1:0]       co_src;

  // Per-stage combinational results.
  logic [NS-1:0][LEN-1:0]      r_n;
  logic [NS-1:0][NL-1:0]       co_n;
  logic [NS-1:0]               c_n;

  logic advance;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign advance  = !v_q[NS-1] | out_ready;
  assign in_ready = advance;

  always_comb begin
    v_src   = '0;
    sub_src = '0;
    cin_src = '0;
    w_src   = '0;
    a_src   = '0;
    b_src   = '0;
    r_src   = '0;
    co_src  = '0;
    v_src[0]   = in_valid;
    sub_src[0] = sub_i;
    w_src[0]   = width_i;
    a_src[0]   = a_i;
    b_src[0]   = b_i;
    for (int s = 1; s < NS; s++) begin
      v_src[s]   = v_q[s-1];
      sub_src[s] = sub_q[s-1];
      cin_src[s] = c_q[s-1];
      w_src[s]   = w_q[s-1];
      a_src[s]   = a_q[s-1];
      b_src[s]   = b_q[s-1];
      r_src[s]   = r_q[s-1];
      co_src[s]  = co_q[s-1];
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_stage
    logic [LEN-1:0] r_v;
    logic [NL-1:0]  co_v;
    logic           c_v;
    logic [32:0]    sum;
    logic [31:0]    bb;
    int             idx;

    always_comb begin
      r_v  = r_src[s];
      co_v = co_src[s];
      c_v  = cin_src[s];
      sum  = '0;
      bb   = '0;
      idx  = 0;
      for (int l = 0; l < LIMBS_PER_STAGE; l++) begin
        idx = s * LIMBS_PER_STAGE + l;
        // Lane start injects the +1 of two's-complement negation (or 0 for add).
        if (lane_start(w_src[s], idx)) c_v = sub_src[s];
        bb  = sub_src[s] ? ~b_src[s][idx*32 +: 32] : b_src[s][idx*32 +: 32];
        sum = {1'b0, a_src[s][idx*32 +: 32]} + {1'b0, bb} + {32'd0, c_v};
        r_v[idx*32 +: 32] = sum[31:0];
        c_v = sum[32];
        co_v[idx] = lane_start(w_src[s], idx + 1) ? c_v : 1'b0;
      end
    end

    assign r_n[s]  = r_v;
    assign co_n[s] = co_v;
    assign c_n[s]  = c_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      sub_q <= '0;
      c_q   <= '0;
      w_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      co_q  <= '0;
    end else if (advance) begin
      v_q   <= v_src;
      sub_q <= sub_src;
      c_q   <= c_n;
      w_q   <= w_src;
      a_q   <= a_src;
      b_q   <= b_src;
      r_q   <= r_n;
      co_q  <= co_n;
    end
  end

  assign out_valid = v_q[NS-1];
  assign res_o     = r_q[NS-1];

  // Operands and mode of the last stage are fully consumed; only results exit.
  logic unused_tail;
`ifdef SIMD_SEG_CARRY_OUT_EN
  assign carry_o     = co_q[NS-1];
  assign unused_tail = ^{a_q[NS-1], b_q[NS-1], w_q[NS-1], sub_q[NS-1], c_q[NS-1]};
`else
  assign unused_tail = ^{a_q[NS-1], b_q[NS-1], w_q[NS-1], sub_q[NS-1], c_q[NS-1], co_q[NS-1]};
`endif

endmodule

// File: tb/tb_simd_seg_addsub.sv
// tb/tb_simd_seg_addsub.sv - scoreboard bench for simd_seg_addsub (LEN=256, LPS=2)
module tb_simd_seg_addsub;

  localparam int LEN = 256;
  localparam int NL  = 8;
  localparam int NS  = 4;

  localparam logic [255:0] ALL_F = {8{32'hFFFFFFFF}};
  localparam logic [255:0] ALL_1 = {8{32'h00000001}};
  localparam logic [255:0] ONE   = 256'h1;
  localparam logic [255:0] V1A = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_00000000_00000000_FFFFFFFF;
  localparam logic [255:0] V1B = 256'h00000000_00000000_00000000_00000001_00000000_00000000_00000000_00000001;
  localparam logic [255:0] E0  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_00000000_00000000_00000000_00000000;
  localparam logic [255:0] E1  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_FFFFFFFE;
  localparam logic [255:0] E3  = 256'h00000000_00000000_00000000_00000000_00000000_00000000_00000001_00000000;
  localparam logic [255:0] E5  = 256'h00000000_00000000_00000000_00000002_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000002;
  localparam logic [255:0] E6  = 256'h00000001_00000001_00000001_00000002_00000000_00000000_00000000_00000002;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, sub_i, out_valid, out_ready;
  logic [LEN-1:0] a_i, b_i, res_o;
  logic [2:0] width_i;
`ifdef SIMD_SEG_CARRY_OUT_EN
  logic [NL-1:0] carry_o;
`endif

  typedef struct {
    logic [255:0] res;
    logic [7:0]   co;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  simd_seg_addsub #(.LEN(LEN), .LIMBS_PER_STAGE(2)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_i(a_i),
    .b_i(b_i),
    .width_i(width_i),
    .sub_i(sub_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SIMD_SEG_CARRY_OUT_EN
    .carry_o(carry_o),
`endif
    .res_o(res_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Monitor: pops and compares on every output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("out_valid_without_pending_beat", {255'b0, out_valid}, 256'h0);
        end else begin
          e = sb.pop_front();
          check("res", res_o, e.res);
`ifdef SIMD_SEG_CARRY_OUT_EN
          check("carry", {248'b0, carry_o}, {248'b0, e.co});
`endif
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Drives one beat, keeps in_valid high on return so calls chain back-to-back.
  task automatic send(input logic [255:0] a, input logic [255:0] b, input logic [2:0] w,
                      input logic s, input logic [255:0] er, input logic [7:0] ec);
    int tries;
    tries = 0;
    in_valid = 1'b1;
    a_i = a;
    b_i = b;
    width_i = w;
    sub_i = s;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{er, ec});
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      tries++;
      if (tries > 50) begin
        check("send_accept_timeout", {255'b0, in_ready}, 256'h1);
        break;
      end
    end
  endtask

  task automatic measure_latency(input string name);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check(name, n, NS);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_complete", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0;
    a_i = '0;
    b_i = '0;
    width_i = '0;
    sub_i = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_out_valid", {255'b0, out_valid}, 256'h0);
    check("reset_in_ready", {255'b0, in_ready}, 256'h1);
    check("reset_res", res_o, 256'h0);
`ifdef SIMD_SEG_CARRY_OUT_EN
    check("reset_carry", {248'b0, carry_o}, 256'h0);
`endif
    @(posedge clk);
    #1;

    // 32-bit lanes, add, exact latency
    send(ALL_F, ALL_1, 3'b000, 1'b0, 256'h0, 8'hFF);
    in_valid = 1'b0;
    measure_latency("latency_32b_add");
    wait_drain();

    // 256-bit carry ripple; 128-bit carry across a stage boundary;
    // width bits after the first zero are ignored (3'b100 means 32-bit lanes)
    send(ALL_F, ONE, 3'b111, 1'b0, 256'h0, 8'h80);
    send({128'h0, {128{1'b1}}}, ONE, 3'b111, 1'b0, ONE << 128, 8'h00);
    send(ALL_F, ALL_1, 3'b100, 1'b0, 256'h0, 8'hFF);
    // 64-bit lanes, 0 - 1
    send(256'h0, {4{64'h1}}, 3'b001, 1'b1, ALL_F, 8'h00);
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back mixed modes
    p0 = pop_cyc.size();
    send(V1A, V1B, 3'b000, 1'b0, E0, 8'h11);
    send(V1A, V1B, 3'b011, 1'b1, E1, 8'h88);
    send(V1A, V1B, 3'b000, 1'b1, E1, 8'hFF);
    send(V1A, V1B, 3'b011, 1'b0, E3, 8'h80);
    send(V1B, V1A, 3'b000, 1'b0, E0, 8'h11);
    send(V1B, V1A, 3'b011, 1'b1, E5, 8'h00);
    send(V1B, V1A, 3'b000, 1'b1, E6, 8'h0E);
    send(V1B, V1A, 3'b011, 1'b0, E3, 8'h80);
    in_valid = 1'b0;
    wait_drain();
    check("mixed_result_count", pop_cyc.size() - p0, 8);
    for (int i = 1; i < 8; i++) begin
      if (p0 + i < pop_cyc.size())
        check("mixed_consecutive", pop_cyc[p0 + i] - pop_cyc[p0 + i - 1], 1);
    end

    // Backpressure: fill, stall 5 cycles with changing inputs, then drain
    out_ready = 1'b0;
    p0 = pop_cyc.size();
    send(V1A, V1B, 3'b000, 1'b0, E0, 8'h11);
    send(V1A, V1B, 3'b011, 1'b1, E1, 8'h88);
    send(V1B, V1A, 3'b000, 1'b1, E6, 8'h0E);
    send(V1A, V1B, 3'b011, 1'b0, E3, 8'h80);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a_i = {8{32'h1111_0000 + 32'(i)}};
      b_i = {8{32'h0000_2222 * 32'(i + 1)}};
      width_i = 3'(i);
      sub_i = i[0];
      @(negedge clk);
      check("stall_in_ready", {255'b0, in_ready}, 256'h0);
      check("stall_out_valid", {255'b0, out_valid}, 256'h1);
      check("stall_res_hold", res_o, E0);
`ifdef SIMD_SEG_CARRY_OUT_EN
      check("stall_carry_hold", {248'b0, carry_o}, 256'h11);
`endif
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("backpressure_result_count", pop_cyc.size() - p0, 4);

    // Reset with 3 beats in flight
    send(ALL_F, ALL_1, 3'b000, 1'b0, 256'h0, 8'hFF);
    send(V1A, V1B, 3'b011, 1'b0, E3, 8'h80);
    send(V1B, V1A, 3'b011, 1'b1, E5, 8'h00);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_out_valid_after_reset", {255'b0, seen}, 256'h0);
    @(posedge clk);
    #1;
    send(ALL_F, ONE, 3'b111, 1'b0, 256'h0, 8'h80);
    in_valid = 1'b0;
    measure_latency("latency_after_reset");
    wait_drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
